// File: rtl/keypad_lock_ctrl.sv
// keypad_lock_ctrl
//   Scans a ROWS x COLS keypad, debounces presses into one-cycle key strobes,
//   collects a CODE_LEN digit access code and drives grant / lockout outputs.
// Ports
//   clk            sole clock, rising edge
//   rst            synchronous active-low reset
//   en             scan / entry enable
//   row            active-high row sense for the currently driven column
//   col            one-hot column drive (0 while disabled)
//   key_valid      one-cycle debounced key strobe
//   key_code       row_idx*COLS+col_idx, valid with key_valid
//   led            thermometer count of digits entered
//   access_granted code matched, held GRANT_CYCLES cycles
//   locked         lockout active, held LOCK_CYCLES cycles
module keypad_lock_ctrl #(
  parameter int ROWS         = 4,
  parameter int COLS         = 4,
  parameter int CODE_LEN     = 4,
  parameter int KW           = $clog2(ROWS*COLS),
  parameter logic [CODE_LEN*KW-1:0] CODE = 16'h1234,
  parameter int CLR_KEY      = ROWS*COLS-1,
  parameter int DEBOUNCE     = 4,
  parameter int MAX_FAIL     = 3,
  parameter int GRANT_CYCLES = 500,
  parameter int LOCK_CYCLES  = 1000
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                en,
  input  logic [ROWS-1:0]     row,
  output logic [COLS-1:0]     col,
  output logic                key_valid,
  output logic [KW-1:0]       key_code,
  output logic [CODE_LEN-1:0] led,
  output logic                access_granted,
  output logic                locked
);

  // state   | meaning
  // IDLE    | no digits held, waiting for the first key
  // ENTRY   | collecting digits
  // CHECK   | one-cycle compare of stored digits against CODE
  // GRANT   | access_granted held for GRANT_CYCLES
  // DENY    | one cycle after a mismatch below the fail limit
  // LOCKOUT | locked held for LOCK_CYCLES, keys ignored
  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_ENTRY   = 3'd1;
  localparam logic [2:0] S_CHECK   = 3'd2;
  localparam logic [2:0] S_GRANT   = 3'd3;
  localparam logic [2:0] S_DENY    = 3'd4;
  localparam logic [2:0] S_LOCKOUT = 3'd5;

  localparam logic [1:0] SC_SCAN    = 2'd0;
  localparam logic [1:0] SC_PRESS   = 2'd1;
  localparam logic [1:0] SC_RELEASE = 2'd2;

  localparam int DBW  = $clog2(DEBOUNCE+1);
  localparam int TMAX = (GRANT_CYCLES > LOCK_CYCLES) ? GRANT_CYCLES : LOCK_CYCLES;
  localparam int TW   = $clog2(TMAX+1);
  localparam int CW   = $clog2(CODE_LEN+1);
  localparam int FW   = $clog2(MAX_FAIL+1);

  logic [1:0]      sc_phase;
  logic [ROWS-1:0] row_q;
  logic [DBW-1:0]  db_cnt;
  logic [KW-1:0]   key_idx;
  logic            row_onehot;
  logic [COLS-1:0] col_rot;

  logic [2:0]      state;
  logic [CW-1:0]   count;
  logic [KW-1:0]   digits [CODE_LEN];
  logic [FW-1:0]   fail_cnt;
  logic [TW-1:0]   timer;
  logic            match;

  function automatic logic [CODE_LEN-1:0] therm(input logic [CW-1:0] n);
    logic [CODE_LEN-1:0] t;
    t = '0;
    for (int i = 0; i < CODE_LEN; i++) t[i] = (i < int'(n));
    return t;
  endfunction

  assign col_rot    = {col[COLS-2:0], col[COLS-1]};
  assign row_onehot = (row_q != '0) && ((row_q & (row_q - ROWS'(1))) == '0);

  always_comb begin
    int ri;
    int ci;
    ri = 0;
    ci = 0;
    for (int r = 0; r < ROWS; r++) if (row_q[r]) ri = r;
    for (int c = 0; c < COLS; c++) if (col[c]) ci = c;
    key_idx = KW'(ri*COLS + ci);
  end

  always_comb begin
    match = 1'b1;
    for (int i = 0; i < CODE_LEN; i++)
      if (digits[i] != CODE[i*KW +: KW]) match = 1'b0;
  end

  // Scanner: rotate until a row senses, freeze col while debouncing, then
  // require DEBOUNCE idle samples before rotating again.
  always_ff @(posedge clk) begin
    if (!rst) begin
      sc_phase  <= SC_SCAN;
      col       <= '0;
      row_q     <= '0;
      db_cnt    <= '0;
      key_valid <= 1'b0;
      key_code  <= '0;
    end else begin
      key_valid <= 1'b0;
      if (!en) begin
        sc_phase <= SC_SCAN;
        col      <= '0;
        row_q    <= '0;
        db_cnt   <= '0;
      end else begin
        case (sc_phase)
          SC_SCAN: begin
            if (col == '0) begin
              col <= COLS'(1);
            end else if (row != '0) begin
              row_q    <= row;
              db_cnt   <= DBW'(DEBOUNCE-1);
              sc_phase <= SC_PRESS;
            end else begin
              col <= col_rot;
            end
          end
          SC_PRESS: begin
            if (row == '0) begin
              sc_phase <= SC_SCAN;
            end else if (row != row_q) begin
              row_q  <= row;
              db_cnt <= DBW'(DEBOUNCE-1);
            end else if (db_cnt <= DBW'(1)) begin
              // the sample that detected the press counts as the first
              if (row_onehot) begin
                key_valid <= 1'b1;
                key_code  <= key_idx;
              end
              db_cnt   <= DBW'(DEBOUNCE);
              sc_phase <= SC_RELEASE;
            end else begin
              db_cnt <= db_cnt - DBW'(1);
            end
          end
          SC_RELEASE: begin
            if (row != '0) begin
              db_cnt <= DBW'(DEBOUNCE);
            end else if (db_cnt <= DBW'(1)) begin
              sc_phase <= SC_SCAN;
              col      <= col_rot;
            end else begin
              db_cnt <= db_cnt - DBW'(1);
            end
          end
          default: sc_phase <= SC_SCAN;
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state          <= S_IDLE;
      count          <= '0;
      led            <= '0;
      fail_cnt       <= '0;
      timer          <= '0;
      access_granted <= 1'b0;
      locked         <= 1'b0;
      for (int i = 0; i < CODE_LEN; i++) digits[i] <= '0;
    end else begin
      case (state)
        S_IDLE, S_ENTRY: begin
          if (!en) begin
            state <= S_IDLE;
            count <= '0;
            led   <= '0;
          end else if (key_valid) begin
            if (key_code == KW'(CLR_KEY)) begin
              state <= S_IDLE;
              count <= '0;
              led   <= '0;
            end else begin
              for (int i = 0; i < CODE_LEN; i++)
                if (count == CW'(i)) digits[i] <= key_code;
              count <= count + CW'(1);
              led   <= therm(count + CW'(1));
              state <= (count == CW'(CODE_LEN-1)) ? S_CHECK : S_ENTRY;
            end
          end
        end
        S_CHECK: begin
          if (match) begin
            state          <= S_GRANT;
            fail_cnt       <= '0;
            access_granted <= 1'b1;
            timer          <= TW'(GRANT_CYCLES-1);
          end else if (int'(fail_cnt) + 1 >= MAX_FAIL) begin
            state    <= S_LOCKOUT;
            fail_cnt <= FW'(MAX_FAIL);
            locked   <= 1'b1;
            timer    <= TW'(LOCK_CYCLES-1);
          end else begin
            state    <= S_DENY;
            fail_cnt <= fail_cnt + FW'(1);
          end
        end
        S_GRANT: begin
          if (timer == '0) begin
            state          <= S_IDLE;
            access_granted <= 1'b0;
            count          <= '0;
            led            <= '0;
          end else begin
            timer <= timer - TW'(1);
          end
        end
        S_DENY: begin
          state <= S_IDLE;
          count <= '0;
          led   <= '0;
        end
        S_LOCKOUT: begin
          if (timer == '0) begin
            state    <= S_IDLE;
            locked   <= 1'b0;
            fail_cnt <= '0;
            count    <= '0;
            led      <= '0;
          end else begin
            timer <= timer - TW'(1);
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_keypad_lock_ctrl.sv
module tb_keypad_lock_ctrl;
  localparam int ROWS = 4;
  localparam int COLS = 4;
  localparam int CLEN = 4;
  localparam int KW   = 4;
  localparam int DEB  = 4;
  localparam int MAXF = 3;
  localparam int GC   = 500;
  localparam int LC   = 1000;
  localparam int CLR  = 15;
  // digit 0 sits at the LSBs and is entered first, so this is the code 1,2,3,4
  localparam logic [15:0] TB_CODE = 16'h4321;

  localparam int O_NONE  = 0;
  localparam int O_GRANT = 1;
  localparam int O_DENY  = 2;
  localparam int O_LOCK  = 3;

  logic            clk = 1'b0;
  logic            rst;
  logic            en;
  logic [ROWS-1:0] row;
  logic [COLS-1:0] col;
  logic            key_valid;
  logic [KW-1:0]   key_code;
  logic [CLEN-1:0] led;
  logic            access_granted;
  logic            locked;
  logic [15:0]     key_mask;

  int passed = 0;
  int total  = 0;
  int cyc    = 0;
  int strobes = 0;

  keypad_lock_ctrl #(
    .ROWS(ROWS), .COLS(COLS), .CODE_LEN(CLEN), .KW(KW), .CODE(TB_CODE),
    .CLR_KEY(CLR), .DEBOUNCE(DEB), .MAX_FAIL(MAXF),
    .GRANT_CYCLES(GC), .LOCK_CYCLES(LC)
  ) dut (
    .clk(clk), .rst(rst), .en(en), .row(row), .col(col),
    .key_valid(key_valid), .key_code(key_code), .led(led),
    .access_granted(access_granted), .locked(locked)
  );

  always #5 clk = ~clk;

  // keypad matrix: a pressed key connects its column drive to its row sense
  always_comb begin
    row = '0;
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++)
        if (key_mask[r*COLS+c] && col[c]) row[r] = 1'b1;
  end

  typedef struct {
    int          key;
    logic [3:0]  led;
    int          outcome;
  } vec_t;
  vec_t vecs[$];

  task automatic tick();
    @(negedge clk);
    cyc++;
    if (key_valid) strobes++;
  endtask

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0d, expected %0d (cycle %0d)", nm, act, exp, cyc);
  endtask

  task automatic wait_until(input int t);
    while (cyc < t) tick();
  endtask

  function automatic int code_digit(input int i);
    return int'((TB_CODE >> (4*i)) & 16'hF);
  endfunction

  function automatic logic [3:0] therm(input int n);
    return 4'((1 << n) - 1);
  endfunction

  task automatic release_keys();
    key_mask = '0;
    repeat (DEB+3) tick();
  endtask

  task automatic press(input int k, output int t_s, output bit ok);
    ok = 1'b0;
    t_s = -1;
    key_mask = 16'(1) << k;
    for (int i = 0; i < 40 && !ok; i++) begin
      tick();
      if (key_valid) begin
        ok = 1'b1;
        t_s = cyc;
      end
    end
    check("strobe_seen", 32'(ok), 1);
    if (ok) check("key_code", 32'(key_code), 32'(k));
  endtask

  task automatic run_entry(input int k, input logic [3:0] exp_led, input int outcome,
                           input bit wait_out);
    int t_s;
    int t2;
    int hold;
    bit ok;
    bit ok2;
    press(k, t_s, ok);
    if (!ok) begin
      release_keys();
      return;
    end
    tick();
    check("led", 32'(led), 32'(exp_led));
    if (outcome == O_NONE) begin
      release_keys();
      return;
    end
    check("result_early", {30'b0, access_granted, locked}, 0);
    tick();
    if (outcome == O_DENY) begin
      check("deny_granted", 32'(access_granted), 0);
      check("deny_locked", 32'(locked), 0);
      tick();
      check("deny_led_clear", 32'(led), 0);
      release_keys();
      return;
    end
    hold = (outcome == O_GRANT) ? GC : LC;
    check(outcome == O_GRANT ? "grant_rise" : "lock_rise",
          32'(outcome == O_GRANT ? access_granted : locked), 1);
    check("other_flag_low", 32'(outcome == O_GRANT ? locked : access_granted), 0);
    release_keys();
    if (!wait_out) return;
    // a key during the hold still strobes but must not be stored
    press($urandom_range(0, 14), t2, ok2);
    release_keys();
    // disabling must not stall the hold timer
    en = 1'b0;
    repeat (20) tick();
    en = 1'b1;
    wait_until(t_s + 1 + hold);
    check("hold_last", 32'(outcome == O_GRANT ? access_granted : locked), 1);
    tick();
    check("hold_end", 32'(outcome == O_GRANT ? access_granted : locked), 0);
    check("led_after_hold", 32'(led), 0);
    repeat (2) tick();
  endtask

  initial begin
    int s0;
    int t_row;
    int t_kv;
    int lat;
    int m_cnt;
    int m_fail;
    int m_dig[$];
    int k;
    int outc;
    logic [3:0] e_led;
    bit m_match;

    rst = 1'b0;
    en = 1'b1;
    key_mask = '0;
    repeat (3) tick();
    check("rst_col", 32'(col), 0);
    check("rst_key_valid", 32'(key_valid), 0);
    check("rst_key_code", 32'(key_code), 0);
    check("rst_led", 32'(led), 0);
    check("rst_granted", 32'(access_granted), 0);
    check("rst_locked", 32'(locked), 0);
    rst = 1'b1;

    // scan rotation and disable
    for (int i = 0; i < 6; i++) begin
      tick();
      check("scan_col", 32'(col), 32'(1 << (i % COLS)));
    end
    en = 1'b0;
    tick();
    check("col_disabled", 32'(col), 0);
    en = 1'b1;
    repeat (3) tick();

    // key 5 held: one strobe, DEB cycles after row settles
    s0 = strobes;
    key_mask = 16'(1) << 5;
    t_row = -1;
    t_kv = -1;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (t_row < 0 && row != '0) t_row = cyc;
      if (t_kv < 0 && key_valid) begin
        t_kv = cyc;
        check("key5_code", 32'(key_code), 5);
      end
    end
    lat = (t_row < 0 || t_kv < 0) ? -1 : t_kv - t_row;
    check("key5_latency", 32'(lat), DEB);
    check("key5_one_strobe", 32'(strobes - s0), 1);
    check("key5_led", 32'(led), 32'(4'b0001));
    release_keys();
    run_entry(6, 4'b0011, O_NONE, 1'b1);
    en = 1'b0;
    tick();
    check("en_off_led", 32'(led), 0);
    check("en_off_col", 32'(col), 0);
    tick();
    en = 1'b1;
    repeat (3) tick();

    // two keys in column 0 give row 0011: rejected, then scan resumes after release
    s0 = strobes;
    key_mask = 16'h0011;
    repeat (15) tick();
    check("multi_col_frozen", 32'(col), 32'(4'b0001));
    check("multi_no_strobe", 32'(strobes - s0), 0);
    key_mask = '0;
    repeat (DEB-1) tick();
    check("multi_still_frozen", 32'(col), 32'(4'b0001));
    tick();
    check("multi_scan_resumed", 32'(col), 32'(4'b0010));
    repeat (3) tick();

    vecs.push_back('{1,  4'b0001, O_NONE});
    vecs.push_back('{2,  4'b0011, O_NONE});
    vecs.push_back('{15, 4'b0000, O_NONE});
    vecs.push_back('{1,  4'b0001, O_NONE});
    vecs.push_back('{2,  4'b0011, O_NONE});
    vecs.push_back('{3,  4'b0111, O_NONE});
    vecs.push_back('{4,  4'b1111, O_GRANT});
    for (int n = 0; n < 3; n++) begin
      vecs.push_back('{1, 4'b0001, O_NONE});
      vecs.push_back('{2, 4'b0011, O_NONE});
      vecs.push_back('{3, 4'b0111, O_NONE});
      vecs.push_back('{5, 4'b1111, (n == 2) ? O_LOCK : O_DENY});
    end
    vecs.push_back('{1, 4'b0001, O_NONE});
    vecs.push_back('{2, 4'b0011, O_NONE});
    vecs.push_back('{3, 4'b0111, O_NONE});
    vecs.push_back('{4, 4'b1111, O_GRANT});
    foreach (vecs[i]) run_entry(vecs[i].key, vecs[i].led, vecs[i].outcome, 1'b1);

    // reset in the middle of a lockout
    for (int n = 0; n < 3; n++) begin
      run_entry(1, 4'b0001, O_NONE, 1'b1);
      run_entry(2, 4'b0011, O_NONE, 1'b1);
      run_entry(3, 4'b0111, O_NONE, 1'b1);
      run_entry(5, 4'b1111, (n == 2) ? O_LOCK : O_DENY, 1'b0);
    end
    repeat (30) tick();
    rst = 1'b0;
    tick();
    check("rst_lock_locked", 32'(locked), 0);
    check("rst_lock_led", 32'(led), 0);
    check("rst_lock_granted", 32'(access_granted), 0);
    check("rst_lock_col", 32'(col), 0);
    check("rst_lock_kv", 32'(key_valid), 0);
    rst = 1'b1;
    repeat (3) tick();
    // fail count cleared: one wrong entry only denies
    run_entry(1, 4'b0001, O_NONE, 1'b1);
    run_entry(2, 4'b0011, O_NONE, 1'b1);
    run_entry(3, 4'b0111, O_NONE, 1'b1);
    run_entry(5, 4'b1111, O_DENY, 1'b1);

    // randomized entries against a digit-list model
    m_cnt = 0;
    m_fail = 1;
    m_dig.delete();
    for (int it = 0; it < 48; it++) begin
      if ($urandom_range(0, 9) == 0 && m_cnt > 0) begin
        en = 1'b0;
        repeat (2) tick();
        check("rnd_en_clear", 32'(led), 0);
        en = 1'b1;
        repeat (3) tick();
        m_cnt = 0;
        m_dig.delete();
      end
      s0 = $urandom_range(0, 99);
      if (s0 < 55) k = code_digit(m_cnt);
      else if (s0 < 65) k = CLR;
      else k = $urandom_range(0, 15);
      outc = O_NONE;
      if (k == CLR) begin
        m_cnt = 0;
        m_dig.delete();
        e_led = 4'b0000;
      end else begin
        m_dig.push_back(k);
        m_cnt++;
        e_led = therm(m_cnt);
        if (m_cnt == CLEN) begin
          m_match = 1'b1;
          for (int i = 0; i < CLEN; i++) if (m_dig[i] != code_digit(i)) m_match = 1'b0;
          if (m_match) begin
            outc = O_GRANT;
            m_fail = 0;
          end else if (m_fail + 1 >= MAXF) begin
            outc = O_LOCK;
            m_fail = 0;
          end else begin
            outc = O_DENY;
            m_fail++;
          end
          m_cnt = 0;
          m_dig.delete();
        end
      end
      run_entry(k, e_led, outc, 1'b1);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/keypad_lock_ctrl.md
KEYPAD_LOCK_CTRL -- requirements
Module: keypad_lock_ctrl

Interface
REQ-001 Parameters SHALL be:
- ROWS, 4, number of keypad rows
- COLS, 4, number of keypad columns
- CODE_LEN, 4, digits per access code
- KW, $clog2(ROWS*COLS), key code width
- CODE, 16'h1234, packed expected code; digit 0 is at LSBs and is entered first
- CLR_KEY, ROWS*COLS-1, key code that clears entry
- DEBOUNCE, 4, stable-sample cycles required
- MAX_FAIL, 3, consecutive failures before lockout
- GRANT_CYCLES, 500, access_granted hold time
- LOCK_CYCLES, 1000, lockout hold time
REQ-002 Ports (name, direction, width, meaning):
- clk, in, 1, sole clock, rising edge
- rst, in, 1, synchronous active-low reset
- en, in, 1, scan/entry enable
- row, in, ROWS, active-high row sense
- col, out, COLS, one-hot column drive
- key_valid, out, 1, one-cycle debounced key strobe
- key_code, out, KW, row_idx*COLS+col_idx; valid with key_valid
- led, out, CODE_LEN, thermometer count of digits entered
- access_granted, out, 1, code matched
- locked, out, 1, lockout active
REQ-003 The block SHALL use one clock, clk; reset SHALL be synchronous and active-low on rst; all outputs SHALL be registered.

Function
REQ-004 Scan: while en=1 and no key is held, col SHALL rotate one-hot each cycle (bit 0 to bit COLS-1, then wrap to bit 0); col SHALL be 0 while en=0.
REQ-005 When row!=0, col SHALL freeze and a debounce counter SHALL count cycles with row unchanged; any change SHALL restart the count.
REQ-006 When row is one-hot and stable for DEBOUNCE cycles, key_valid SHALL pulse for exactly 1 cycle with key_code; a multi-bit row SHALL produce no strobe.
REQ-007 After a strobe or a rejected multi-bit press, scan SHALL resume only after row=0 for DEBOUNCE consecutive cycles; holding a key SHALL produce one strobe only.
REQ-008 FSM states SHALL be IDLE, ENTRY, CHECK, GRANT, DENY, LOCKOUT.
REQ-009 IDLE/ENTRY: each non-CLR key SHALL be stored in the next digit slot and the digit count incremented; the first key moves IDLE to ENTRY; led SHALL equal the thermometer of the count.
REQ-010 CLR_KEY in IDLE/ENTRY SHALL zero the count, set led=0, return to IDLE and leave fail_cnt unchanged.
REQ-011 When the count reaches CODE_LEN, the FSM SHALL enter CHECK on the next cycle, compare all digits with CODE, then leave CHECK after 1 cycle.
REQ-012 Match: GRANT; fail_cnt:=0; access_granted=1 from the cycle after CHECK for exactly GRANT_CYCLES cycles, then IDLE with led=0.
REQ-013 Mismatch with fail_cnt+1<MAX_FAIL: fail_cnt++; DENY for 1 cycle, then IDLE with led=0.
REQ-014 Mismatch with fail_cnt+1=MAX_FAIL: LOCKOUT; locked=1 for exactly LOCK_CYCLES cycles, then IDLE with fail_cnt:=0.
REQ-015 Keys strobed in CHECK, GRANT, DENY or LOCKOUT SHALL be ignored and not stored; key_valid still pulses.
REQ-016 en=0 in IDLE/ENTRY SHALL clear the count and led and force IDLE; en=0 SHALL NOT stop GRANT or LOCKOUT timers, alter fail_cnt, or abort CHECK.
REQ-017 Timers SHALL be wide enough for GRANT_CYCLES and LOCK_CYCLES without wrap; fail_cnt SHALL saturate at MAX_FAIL.

Reset
REQ-018 With rst=0 at a clk edge: state=IDLE, col=0, key_valid=0, key_code=0, led=0, access_granted=0, locked=0, fail_cnt=0, count=0, debounce and timers=0; this SHALL abort any state, including LOCKOUT.

Verification
REQ-019 Press key 5 (row 1, col 1) held 10 cycles -> exactly one key_valid with key_code=5, DEBOUNCE cycles after row stabilises.
REQ-020 Enter 1,2,3,4 -> led 0001, 0011, 0111, 1111; access_granted rises 2 cycles after the 4th strobe and holds 500 cycles.
REQ-021 Enter 1,2,3,5 three times -> DENY, DENY, then locked=1 for 1000 cycles with keys ignored; afterwards 1,2,3,4 grants.
REQ-022 Enter 1,2 then CLR_KEY(15) then 1,2,3,4 -> led returns to 0 at the clear; access granted.
REQ-023 Row=4'b0011 held -> no key_valid; scan resumes DEBOUNCE cycles after release.
REQ-024 rst=0 during LOCKOUT, or en=0 after 2 digits -> all outputs at reset values / led=0, state IDLE.
